// File: rtl/hs32_bus_pkg.sv
// Shared definitions for the hs32 memory-bus bridge: FSM state encoding,
// read/write direction codes, the timeout error pattern and the byte-lane
// merge used by read-modify-write.
package hs32_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_WR     = 3'd2,
        ST_RMW_RD = 3'd3,
        ST_RMW_WR = 3'd4,
        ST_ACK    = 3'd5
    } bridge_state_t;

    localparam logic        RW_READ     = 1'b0;
    localparam logic        RW_WRITE    = 1'b1;
    localparam logic [31:0] ERR_PATTERN = 32'hDEAD_BEEF;
    localparam logic [3:0]  SEL_ALL     = 4'hF;
    localparam logic [3:0]  SEL_NONE    = 4'h0;

    // Lane n takes the new write byte when sel[n] is set, else keeps the
    // byte just read back from memory.
    function automatic logic [31:0] merge_lanes(input logic [3:0]  sel,
                                                input logic [31:0] wr_data,
                                                input logic [31:0] rd_data);
        logic [31:0] merged;
        merged = rd_data;
        for (int n = 0; n < 4; n++) begin
            merged[8*n +: 8] = sel[n] ? wr_data[8*n +: 8] : rd_data[8*n +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/hs32_wb_addr_decode.sv
// Combinational window decode: flags a Wishbone byte address as inside the
// 2^addr_width window at BASE_ADDR and produces the word-aligned offset.
module hs32_wb_addr_decode #(
    parameter int          addr_width = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000
) (
    input  logic [31:0]           i_adr,
    output logic                  o_hit,
    output logic [addr_width-1:0] o_offset
);

    localparam logic [31:0] WIN_MASK = (32'h1 << addr_width) - 32'h1;

    assign o_hit    = ((i_adr & ~WIN_MASK) == BASE_ADDR);
    assign o_offset = {i_adr[addr_width-1:2], 2'b00};

endmodule

// File: rtl/hs32_wb_mem_bridge.sv
// Wishbone classic slave that forwards single-word accesses onto the hs32
// memory bus (strobe/ack initiator). Partial byte-select writes are done
// as read-modify-write. Optional ack timeout: define HS32_WB_TIMEOUT_EN.
module hs32_wb_mem_bridge
    import hs32_bus_pkg::*;
#(
    parameter int          addr_width = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000
`ifdef HS32_WB_TIMEOUT_EN
    , parameter int        TIMEOUT_CYCLES = 16
`endif
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_we_i,
    input  logic [3:0]            wbs_sel_i,
    input  logic [31:0]           wbs_adr_i,
    input  logic [31:0]           wbs_dat_i,
    output logic                  wbs_ack_o,
    output logic [31:0]           wbs_dat_o,
    output logic [addr_width-1:0] o_addr,
    output logic [31:0]           o_dwrite,
    output logic                  o_rw,
    output logic                  o_stb,
    input  logic                  i_ack,
    input  logic [31:0]           i_dread,
    output logic                  o_busy,
    output logic                  o_err
);

    // Handshakes: a Wishbone request is taken in IDLE when cyc & stb are high
    // and ack is low; wbs_ack_o pulses for one cycle in ACK (only while cyc
    // is still high). On the memory side o_stb pulses on the first cycle of
    // each memory state and the bridge then waits for i_ack in that state.

    bridge_state_t         r_state;
    bridge_state_t         w_state_next;
    logic                  w_hit;
    logic [addr_width-1:0] w_offset;
    logic                  w_accept;
    logic                  w_direct_ack;
    logic                  w_mem_state;
    logic                  w_timeout;
    logic [addr_width-1:0] r_addr;
    logic [31:0]           r_dwrite;
    logic [31:0]           r_rdata;
    logic [3:0]            r_sel;
    logic                  r_stb;

    hs32_wb_addr_decode #(
        .addr_width (addr_width),
        .BASE_ADDR  (BASE_ADDR)
    ) u_decode (
        .i_adr    (wbs_adr_i),
        .o_hit    (w_hit),
        .o_offset (w_offset)
    );

    assign w_accept     = (r_state == ST_IDLE) && wbs_cyc_i && wbs_stb_i && !wbs_ack_o;
    assign w_direct_ack = !w_hit || (wbs_we_i && (wbs_sel_i == SEL_NONE));
    assign w_mem_state  = (r_state == ST_RD) || (r_state == ST_WR) ||
                          (r_state == ST_RMW_RD) || (r_state == ST_RMW_WR);

`ifdef HS32_WB_TIMEOUT_EN
    localparam int            TW       = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] r_tmo_cnt;
    logic          r_err;

    assign w_timeout = w_mem_state && !i_ack && (r_tmo_cnt == TMO_LAST);
    assign o_err     = r_err;

    // Cycles spent waiting in the current memory state, restarted on entry.
    always_ff @(posedge i_clk) begin
        if (i_reset || (w_state_next != r_state)) begin
            r_tmo_cnt <= '0;
        end else if (w_mem_state) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign o_err     = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_direct_ack)               w_state_next = ST_ACK;
                    else if (!wbs_we_i)             w_state_next = ST_RD;
                    else if (wbs_sel_i == SEL_ALL)  w_state_next = ST_WR;
                    else                            w_state_next = ST_RMW_RD;
                end
            end
            ST_RD, ST_WR, ST_RMW_WR: begin
                if (i_ack || w_timeout) w_state_next = ST_ACK;
            end
            ST_RMW_RD: begin
                if (i_ack)          w_state_next = ST_RMW_WR;
                else if (w_timeout) w_state_next = ST_ACK;
            end
            ST_ACK:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        o_busy    = (r_state != ST_IDLE);
        o_rw      = ((r_state == ST_WR) || (r_state == ST_RMW_WR)) ? RW_WRITE : RW_READ;
        wbs_ack_o = (r_state == ST_ACK) && wbs_cyc_i;
    end

    // Memory strobe: one pulse on the first cycle of every memory state.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stb <= 1'b0;
        end else begin
            r_stb <= (w_state_next != r_state) &&
                     (w_state_next inside {ST_RD, ST_WR, ST_RMW_RD, ST_RMW_WR});
        end
    end

    // Request capture, read-data return and RMW lane merge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_addr   <= '0;
            r_dwrite <= '0;
            r_sel    <= '0;
            r_rdata  <= '0;
        end else begin
            if (w_accept) begin
                r_addr   <= w_offset;
                r_dwrite <= wbs_dat_i;
                r_sel    <= wbs_sel_i;
                if (w_direct_ack) r_rdata <= '0;
            end
            if (r_state == ST_RD) begin
                if (i_ack)          r_rdata <= i_dread;
                else if (w_timeout) r_rdata <= ERR_PATTERN;
            end
            if ((r_state == ST_RMW_RD) && i_ack) begin
                r_dwrite <= merge_lanes(r_sel, r_dwrite, i_dread);
            end
        end
    end

    assign o_stb     = r_stb;
    assign o_addr    = r_addr;
    assign o_dwrite  = r_dwrite;
    assign wbs_dat_o = r_rdata;

endmodule

// File: tb/tb_hs32_wb_mem_bridge.sv
// Bench for hs32_wb_mem_bridge: a 1-cycle-ack memory responder, a word-array
// reference of memory contents and expected bus behaviour, directed cases
// followed by randomized Wishbone traffic.
module tb_hs32_wb_mem_bridge;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        wbs_cyc_i = 1'b0;
    logic        wbs_stb_i = 1'b0;
    logic        wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'h0;
    logic [31:0] wbs_adr_i = 32'h0;
    logic [31:0] wbs_dat_i = 32'h0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [11:0] o_addr;
    logic [31:0] o_dwrite;
    logic        o_rw;
    logic        o_stb;
    logic        i_ack = 1'b0;
    logic [31:0] i_dread = 32'h0;
    logic        o_busy;
    logic        o_err;

    hs32_wb_mem_bridge dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .o_addr    (o_addr),
        .o_dwrite  (o_dwrite),
        .o_rw      (o_rw),
        .o_stb     (o_stb),
        .i_ack     (i_ack),
        .i_dread   (i_dread),
        .o_busy    (o_busy),
        .o_err     (o_err)
    );

    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem     [1024];
    logic [31:0] ref_mem [1024];
    logic [31:0] exp_rdata_hold = 32'h0;

    logic [31:0] stb_rw_q[$];
    logic [31:0] stb_addr_q[$];
    logic [31:0] stb_dat_q[$];

    bit          mem_ack_en = 1'b1;
    logic        pend = 1'b0;
    logic        pend_rw = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    logic [31:0] pend_dat = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory responder: acks one cycle after each strobe, logs strobes.
    always @(negedge i_clk) begin
        i_ack = pend;
        if (pend) begin
            i_dread = mem[pend_addr[11:2]];
            if (pend_rw) mem[pend_addr[11:2]] = pend_dat;
        end else begin
            i_dread = $urandom;
        end
        pend = o_stb && mem_ack_en;
        if (o_stb) begin
            pend_addr = {20'h0, o_addr};
            pend_rw   = o_rw;
            pend_dat  = o_dwrite;
            stb_rw_q.push_back({31'h0, o_rw});
            stb_addr_q.push_back({20'h0, o_addr});
            stb_dat_q.push_back(o_dwrite);
        end
    end

    task automatic clear_logs();
        stb_rw_q.delete();
        stb_addr_q.delete();
        stb_dat_q.delete();
    endtask

    task automatic run_txn(input logic we, input logic [3:0] sel,
                           input logic [31:0] adr, input logic [31:0] dat);
        int          idx;
        bit          hit;
        bit          direct;
        bit          got;
        int          exp_lat;
        int          exp_stb;
        int          lat;
        logic [31:0] old_w;
        logic [31:0] new_w;
        logic [31:0] got_dat;
        idx    = int'(adr[11:2]);
        hit    = ((adr & 32'hFFFF_F000) == BASE);
        direct = !hit || (we && (sel == 4'h0));
        old_w  = ref_mem[idx];
        for (int b = 0; b < 4; b++) begin
            new_w[8*b +: 8] = sel[b] ? dat[8*b +: 8] : old_w[8*b +: 8];
        end
        if (direct) begin
            exp_lat = 1; exp_stb = 0; exp_rdata_hold = 32'h0;
        end else if (!we) begin
            exp_lat = 3; exp_stb = 1; exp_rdata_hold = old_w;
        end else if (sel == 4'hF) begin
            exp_lat = 3; exp_stb = 1; ref_mem[idx] = new_w;
        end else begin
            exp_lat = 5; exp_stb = 2; ref_mem[idx] = new_w;
        end
        clear_logs();
        @(negedge i_clk);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_sel_i = sel;  wbs_adr_i = adr;  wbs_dat_i = dat;
        lat = 0; got = 1'b0; got_dat = 'x;
        for (int c = 0; c < 50 && !got; c++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            lat++;
            if (wbs_ack_o) begin
                got = 1'b1;
                got_dat = wbs_dat_o;
            end
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        chk("ack_seen", {31'h0, got}, 32'h1);
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("rdata", got_dat, exp_rdata_hold);
        chk("stb_count", 32'(stb_rw_q.size()), 32'(exp_stb));
        for (int k = 0; k < stb_addr_q.size() && k < exp_stb; k++) begin
            chk("stb_addr", stb_addr_q[k], adr & 32'h0000_0FFC);
        end
        if (exp_stb == 1 && stb_rw_q.size() >= 1) begin
            chk("stb_rw", stb_rw_q[0], {31'h0, we});
            if (we) chk("wr_data", stb_dat_q[0], new_w);
        end
        if (exp_stb == 2 && stb_rw_q.size() >= 2) begin
            chk("rmw_rw0", stb_rw_q[0], 32'h0);
            chk("rmw_rw1", stb_rw_q[1], 32'h1);
            chk("rmw_data", stb_dat_q[1], new_w);
        end
        @(posedge i_clk);
        @(negedge i_clk);
        chk("idle_after", {31'h0, o_busy}, 32'h0);
    endtask

    task automatic preload(input int idx, input logic [31:0] v);
        mem[idx] = v;
        ref_mem[idx] = v;
    endtask

    initial begin
        int          acks;
        int          idx;
        int          k;
        logic [31:0] adr;
        logic [31:0] v;
        for (int i = 0; i < 1024; i++) begin
            v = $urandom;
            mem[i] = v;
            ref_mem[i] = v;
        end

        // Reset state
        i_reset = 1'b1;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_ack", {31'h0, wbs_ack_o}, 32'h0);
        chk("rst_dat", wbs_dat_o, 32'h0);
        chk("rst_addr", {20'h0, o_addr}, 32'h0);
        chk("rst_dwrite", o_dwrite, 32'h0);
        chk("rst_rw", {31'h0, o_rw}, 32'h0);
        chk("rst_stb", {31'h0, o_stb}, 32'h0);
        chk("rst_busy", {31'h0, o_busy}, 32'h0);
        chk("rst_err", {31'h0, o_err}, 32'h0);
        i_reset = 1'b0;

        // Directed: read, full write + readback, RMW, miss, zero-sel write
        preload(4, 32'h1122_3344);
        run_txn(1'b0, 4'h0, 32'h3000_0010, 32'h0);
        run_txn(1'b1, 4'hF, 32'h3000_0020, 32'hCAFE_F00D);
        run_txn(1'b0, 4'hF, 32'h3000_0020, 32'h0);
        preload(12, 32'hAABB_CCDD);
        run_txn(1'b1, 4'b0101, 32'h3000_0030, 32'h1122_3344);
        if (stb_dat_q.size() >= 2) chk("rmw_const", stb_dat_q[1], 32'hAA22_CC44);
        run_txn(1'b0, 4'hF, 32'h3000_0030, 32'h0);
        run_txn(1'b0, 4'hF, 32'h2000_0000, 32'h0);
        run_txn(1'b1, 4'h0, 32'h3000_0030, 32'h5555_5555);
        run_txn(1'b1, 4'hF, 32'h3000_1000, 32'h7777_7777);

        // Reset during the RMW read phase
        clear_logs();
        @(negedge i_clk);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_sel_i = 4'b0011; wbs_adr_i = BASE | 32'h40; wbs_dat_i = $urandom;
        @(posedge i_clk);
        @(negedge i_clk);
        chk("mid_stb", {31'h0, o_stb}, 32'h1);
        chk("mid_busy", {31'h0, o_busy}, 32'h1);
        i_reset = 1'b1; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        chk("abort_stb", {31'h0, o_stb}, 32'h0);
        chk("abort_busy", {31'h0, o_busy}, 32'h0);
        chk("abort_ack", {31'h0, wbs_ack_o}, 32'h0);
        chk("abort_dat", wbs_dat_o, 32'h0);
        chk("abort_addr", {20'h0, o_addr}, 32'h0);
        chk("abort_dwrite", o_dwrite, 32'h0);
        i_reset = 1'b0;
        exp_rdata_hold = 32'h0;
        acks = 0;
        repeat (4) begin
            @(posedge i_clk);
            @(negedge i_clk);
            if (wbs_ack_o) acks++;
        end
        chk("abort_no_ack", 32'(acks), 32'h0);
        chk("abort_stb_count", 32'(stb_rw_q.size()), 32'h1);
        run_txn(1'b0, 4'hF, BASE | 32'h40, 32'h0);

        // Cycle dropped mid-write: memory op completes, ack suppressed
        clear_logs();
        v = $urandom;
        @(negedge i_clk);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_sel_i = 4'hF; wbs_adr_i = BASE | 32'h44; wbs_dat_i = v;
        ref_mem[17] = v;
        @(posedge i_clk);
        @(negedge i_clk);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        acks = 0;
        repeat (6) begin
            @(posedge i_clk);
            @(negedge i_clk);
            if (wbs_ack_o) acks++;
        end
        chk("drop_no_ack", 32'(acks), 32'h0);
        chk("drop_busy", {31'h0, o_busy}, 32'h0);
        chk("drop_stb_count", 32'(stb_rw_q.size()), 32'h1);
        run_txn(1'b0, 4'hF, BASE | 32'h44, 32'h0);

        // Randomized traffic
        for (int t = 0; t < 60; t++) begin
            idx = $urandom_range(0, 15);
            if (idx > 7) idx += 1008;
            adr = BASE | (32'(idx) << 2) | 32'($urandom_range(0, 3));
            k = $urandom_range(0, 9);
            v = $urandom;
            if (k <= 2)      run_txn(1'b0, 4'($urandom_range(0, 15)), adr, v);
            else if (k <= 4) run_txn(1'b1, 4'hF, adr, v);
            else if (k <= 7) run_txn(1'b1, 4'($urandom_range(1, 14)), adr, v);
            else if (k == 8) run_txn(1'b1, 4'h0, adr, v);
            else begin
                adr = $urandom;
                if ((adr & 32'hFFFF_F000) == BASE) adr = adr ^ 32'h8000_0000;
                run_txn(1'($urandom_range(0, 1)), 4'hF, adr, v);
            end
        end

`ifdef HS32_WB_TIMEOUT_EN
        // Memory never acks: abort with error pattern and sticky o_err
        mem_ack_en = 1'b0;
        @(negedge i_clk);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_sel_i = 4'hF; wbs_adr_i = BASE | 32'h8;
        acks = 0; k = 0;
        for (int c = 0; c < 60 && acks == 0; c++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            k++;
            if (wbs_ack_o) begin
                acks = 1;
                v = wbs_dat_o;
            end
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        chk("tmo_ack", 32'(acks), 32'h1);
        chk("tmo_latency", 32'(k), 32'd17);
        chk("tmo_dat", v, 32'hDEAD_BEEF);
        chk("tmo_err", {31'h0, o_err}, 32'h1);
        mem_ack_en = 1'b1;
        repeat (5) @(posedge i_clk);
        @(negedge i_clk);
        chk("tmo_err_sticky", {31'h0, o_err}, 32'h1);
        i_reset = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
        chk("tmo_err_cleared", {31'h0, o_err}, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
